scarv_cop_issue_ctrl: RTL and testbench
=======================================

# scarv_cop_issue_ctrl

Instruction issue controller for the SCARV cryptographic coprocessor. It accepts one ISE instruction at a time from the host core over a valid/ready handshake and holds it steady for the combinatorial instruction decoder. It then dispatches the instruction to the functional unit selected by the decoded class, sequences the register-file init operation, enforces a functional-unit timeout, and returns a status response to the core. It sits between the core's coprocessor interface and the decoder plus functional units.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles in WAIT before the instruction is aborted. Legal range 1..255.
- `NUM_CPRS`, default 16: number of coprocessor registers cleared by init. Fixed at 16; the address is 4 bits.

Ports:
- `g_clk` in 1: clock; all state updates on the rising edge.
- `g_resetn` in 1: asynchronous active-low reset.
- `cpu_insn_req` in 1: instruction valid from the core.
- `cpu_insn_ack` out 1: ready to accept an instruction.
- `cpu_insn_enc` in 32: encoded instruction.
- `cpu_rsp_valid` out 1: response valid.
- `cpu_rsp_ack` in 1: core accepts the response.
- `cpu_rsp_status` out 2: 00 success, 01 illegal instruction, 10 timeout, 11 reserved (never driven).
- `id_encoded` out 32: latched instruction driven to the decoder.
- `id_exception` in 1: decoder illegal-instruction flag.
- `id_class` in 9: decoder one-hot class vector.
- `id_cprs_init` in 1: decoder flag for the init instruction.
- `fu_ivalid` out 9: one-hot issue strobe, indexed identically to `id_class`.
- `fu_idone` in 9: per-unit completion pulses.
- `crf_init_en` out 1: register-file clear write enable.
- `crf_init_addr` out 4: register address being cleared.

## Operation

The controller uses five states: IDLE, DECODE, WAIT, INIT and RESP.

- **IDLE:**
  - `cpu_insn_ack`=1.
  - On `cpu_insn_req`&&`cpu_insn_ack`: latch `cpu_insn_enc` into `id_encoded`, then go to DECODE.
  - `id_encoded` is updated only on an accept and otherwise holds its value.
- **DECODE:** one cycle. The decoder outputs are sampled at the end of this cycle, with priority in the order below.
  1. `id_exception`=1 → RESP, status 01.
  2. `id_cprs_init`=1 → INIT with `crf_init_addr`=0. This holds even when `id_class`=0.
  3. `id_class` has zero bits set, or more than one bit set → RESP, status 01.
  4. Otherwise → WAIT. Load the registered `fu_ivalid` with `id_class` and clear the timeout counter to 0.
- **WAIT:**
  - `fu_ivalid` holds its one-hot value.
  - The counter increments each cycle.
  - If `fu_idone & fu_ivalid` is nonzero → RESP, status 00, and `fu_ivalid` clears.
  - `fu_idone` bits outside the issued class are ignored.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES`-1 → RESP, status 10, and `fu_ivalid` clears.
  - If done and timeout occur in the same cycle, done wins and status is 00.
- **INIT:**
  - `crf_init_en`=1 with `crf_init_addr`=0,1,…,15 on consecutive cycles.
  - After address 15 → RESP, status 00; `crf_init_en` and `crf_init_addr` both return to 0.
- **RESP:**
  - `cpu_rsp_valid`=1 and `cpu_rsp_status` are held stable until `cpu_rsp_ack`.
  - On ack → IDLE; `cpu_rsp_valid` drops the next cycle.
  - No new instruction is accepted until IDLE is reached.
- **Reset values** (any time, including mid-operation):
  - State IDLE.
  - `cpu_insn_ack`=1 while reset is released.
  - `cpu_rsp_valid`=0, `cpu_rsp_status`=00.
  - `id_encoded`=0, `fu_ivalid`=0.
  - `crf_init_en`=0, `crf_init_addr`=0.
  - Counter 0.
  - An instruction in progress is dropped silently, with no response.
- **Output timing:** all outputs are registered or decoded from state only; none has a combinational path from inputs.

## Timing

Relative to the accept edge T:
- Instruction is in DECODE during T+1.
- `fu_ivalid` is high from T+2.
- `fu_idone` sampled high in cycle D gives `cpu_rsp_valid` high in D+1.
- Minimum total time from accept to response is 3 cycles (done in the first WAIT cycle).
- Illegal instruction: response at T+2.
- Init: `crf_init_en` is high for T+2..T+17 and the response is at T+18.
- Timeout: `fu_ivalid` is high for exactly `TIMEOUT_CYCLES` cycles and the response appears the next cycle.
- A response acknowledged in cycle A gives `cpu_insn_ack`=1 in A+1, and the next instruction can be accepted in A+1.
- `cpu_rsp_ack` is ignored outside RESP. `cpu_insn_req` is ignored outside IDLE.

## Test plan

- **Normal issue:** accept insn X; decoder class=9'b000000100; `fu_idone[2]` is pulsed 4 cycles after `fu_ivalid` rises. Required: `id_encoded`=X from T+1; `fu_ivalid`=9'h004 for 5 cycles; response status 00 one cycle after done; ack in the same cycle returns to IDLE.
- **Illegal instruction:** `id_exception`=1. Required: `fu_ivalid` never asserts; `cpu_rsp_valid` at T+2 with status 01. Repeat with `id_class`=9'h003 and with `id_class`=0: same result.
- **Init:** `id_cprs_init`=1. Required: `crf_init_en` high 16 cycles with addresses 0..15 in order; then status 00; no `fu_ivalid` activity.
- **Timeout:** `TIMEOUT_CYCLES`=8 and `fu_idone` held at 0; then a second run with a foreign `fu_idone[5]` pulse while class bit 0 is issued. Required: `fu_ivalid` high exactly 8 cycles; status 10 in both runs.
- **Response backpressure and boundary:** hold `cpu_rsp_ack`=0 for 10 cycles and toggle `cpu_insn_req`. Required: status stable, `cpu_insn_ack`=0, no new latch. Also drive done on the last timeout cycle: required status 00.
- **Reset mid-WAIT and mid-INIT:** assert `g_resetn` low asynchronously. Required: all outputs take their reset values immediately without waiting for a clock edge; no response is issued; after release the next instruction is accepted normally.

Source files
------------

// File: rtl/scarv_cop_issue_ctrl_if.sv
// Bus bundle between the issue controller, the host core's coprocessor
// port, the instruction decoder and the functional units.
// slave  : the issue controller's view.
// master : the surrounding environment's view (core, decoder, FUs).
interface scarv_cop_issue_ctrl_if;
  // Core instruction channel
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;

  // Core response channel
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ack;
  logic [1:0]  cpu_rsp_status;

  // Decoder
  logic [31:0] id_encoded;
  logic        id_exception;
  logic [8:0]  id_class;
  logic        id_cprs_init;

  // Functional units and register-file clear
  logic [8:0]  fu_ivalid;
  logic [8:0]  fu_idone;
  logic        crf_init_en;
  logic [3:0]  crf_init_addr;

  modport slave (
    input  cpu_insn_req, cpu_insn_enc, cpu_rsp_ack,
    input  id_exception, id_class, id_cprs_init, fu_idone,
    output cpu_insn_ack, cpu_rsp_valid, cpu_rsp_status,
    output id_encoded, fu_ivalid, crf_init_en, crf_init_addr
  );

  modport master (
    output cpu_insn_req, cpu_insn_enc, cpu_rsp_ack,
    output id_exception, id_class, id_cprs_init, fu_idone,
    input  cpu_insn_ack, cpu_rsp_valid, cpu_rsp_status,
    input  id_encoded, fu_ivalid, crf_init_en, crf_init_addr
  );
endinterface

// File: rtl/scarv_cop_issue_ctrl.sv
// SCARV coprocessor instruction issue controller.
// Accepts one instruction at a time, holds it for the combinational decoder,
// dispatches it to the selected functional unit (or runs the register-file
// clear sequence), enforces a completion timeout and returns a status.
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module scarv_cop_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int NUM_CPRS       = 16
) (
  input  logic                        g_clk,
  input  logic                        g_resetn,
  scarv_cop_issue_ctrl_if.slave       bus
);

  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] ADDR_LAST = 4'(NUM_CPRS - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_INIT,
    S_RESP
  } state_t;

  state_t      state_q,  state_d;
  logic [31:0] enc_q,    enc_d;
  logic [8:0]  ivalid_q, ivalid_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [3:0]  addr_q,   addr_d;

  logic        class_onehot;
  logic        fu_done;

  // A class vector is usable only with exactly one bit set.
  assign class_onehot = (bus.id_class != 9'd0) &&
                        ((bus.id_class & (bus.id_class - 9'd1)) == 9'd0);

  // Completion pulses from units other than the issued one are ignored.
  assign fu_done = |(bus.fu_idone & ivalid_q);

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d  = state_q;
    enc_d    = enc_q;
    ivalid_d = ivalid_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    unique case (state_q)
      S_IDLE: begin
        // The ready side is high in IDLE, so a request alone is an accept.
        if (bus.cpu_insn_req) begin
          enc_d   = bus.cpu_insn_enc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.id_exception) begin
          status_d = ST_ILLEGAL;
          state_d  = S_RESP;
        end else if (bus.id_cprs_init) begin
          // Init needs no functional unit, so the class vector is irrelevant.
          addr_d  = 4'd0;
          state_d = S_INIT;
        end else if (!class_onehot) begin
          status_d = ST_ILLEGAL;
          state_d  = S_RESP;
        end else begin
          ivalid_d = bus.id_class;
          cnt_d    = 8'd0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Done is tested first so a completion on the last cycle still wins.
        if (fu_done) begin
          status_d = ST_OK;
          ivalid_d = 9'd0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          status_d = ST_TIMEOUT;
          ivalid_d = 9'd0;
          state_d  = S_RESP;
        end
      end
      S_INIT: begin
        if (addr_q == ADDR_LAST) begin
          addr_d   = 4'd0;
          status_d = ST_OK;
          state_d  = S_RESP;
        end else begin
          addr_d = addr_q + 4'd1;
        end
      end
      S_RESP: begin
        if (bus.cpu_rsp_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= S_IDLE;
      enc_q    <= 32'd0;
      ivalid_q <= 9'd0;
      status_q <= 2'b00;
      cnt_q    <= 8'd0;
      addr_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      enc_q    <= enc_d;
      ivalid_q <= ivalid_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.cpu_insn_ack   = (state_q == S_IDLE);
  assign bus.cpu_rsp_valid  = (state_q == S_RESP);
  assign bus.cpu_rsp_status = status_q;
  assign bus.id_encoded     = enc_q;
  assign bus.fu_ivalid      = ivalid_q;
  assign bus.crf_init_en    = (state_q == S_INIT);
  assign bus.crf_init_addr  = addr_q;

endmodule

// File: tb/tb_scarv_cop_issue_ctrl.sv
// Self-checking bench for scarv_cop_issue_ctrl: directed corner cases plus
// randomized transactions, each compared against a transaction-level model
// that predicts status, response latency and strobe counts.
module tb_scarv_cop_issue_ctrl;

  localparam int TO    = 8;
  localparam int BOUND = 60;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;

  scarv_cop_issue_ctrl_if bus ();

  scarv_cop_issue_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .NUM_CPRS       (16)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  always #5 g_clk = ~g_clk;

  int n_chk = 0;
  int n_err = 0;
  bit noise_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  // kind: 0 = plain issue, 1 = decoder exception, 2 = init.
  // d: WAIT cycle (0-based) in which the issued unit signals done.
  function automatic void model(input int kind, input logic [8:0] cls, input int d,
                                output int st, output int rsp_at,
                                output int iv_n, output int init_n);
    iv_n   = 0;
    init_n = 0;
    if (kind == 1) begin
      st = 1; rsp_at = 2;
    end else if (kind == 2) begin
      st = 0; rsp_at = 18; init_n = 16;
    end else if ($countones(cls) != 1) begin
      st = 1; rsp_at = 2;
    end else if (d < TO) begin
      st = 0; rsp_at = 3 + d; iv_n = d + 1;
    end else begin
      st = 2; rsp_at = 2 + TO; iv_n = TO;
    end
  endfunction

  task automatic set_dec(input int kind, input logic [8:0] cls);
    bus.id_exception = (kind == 1);
    bus.id_cprs_init = (kind == 2);
    bus.id_class     = cls;
  endtask

  task automatic accept(input logic [31:0] enc);
    chk("idle_ack", 32'(bus.cpu_insn_ack), 32'd1);
    bus.cpu_insn_req = 1'b1;
    bus.cpu_insn_enc = enc;
    cyc();
    bus.cpu_insn_req = 1'b0;
    bus.cpu_insn_enc = $urandom;
    chk("latch", bus.id_encoded, enc);
  endtask

  task automatic run_txn(input int kind, input logic [8:0] cls, input int d, input int bp);
    logic [31:0] enc;
    logic [8:0]  noise;
    logic [1:0]  st_seen;
    int st, rsp_at, iv_exp, init_exp;
    int c, rsp_c, iv_n, init_n, iv_bad, addr_bad, ack_bad, bp_bad;
    bit got;
    enc = $urandom;
    model(kind, cls, d, st, rsp_at, iv_exp, init_exp);
    set_dec(kind, cls);
    accept(enc);
    c = 1; got = 0; rsp_c = -1;
    iv_n = 0; init_n = 0; iv_bad = 0; addr_bad = 0; ack_bad = 0;
    while (!got && c <= BOUND) begin
      if (bus.cpu_rsp_valid) begin
        got = 1; rsp_c = c;
      end else begin
        if (bus.cpu_insn_ack || bus.id_encoded !== enc) ack_bad++;
        if (bus.fu_ivalid != 9'd0) begin
          iv_n++;
          if (bus.fu_ivalid !== cls) iv_bad++;
        end
        if (bus.crf_init_en) begin
          if (32'(bus.crf_init_addr) != init_n) addr_bad++;
          init_n++;
        end else if (bus.crf_init_addr != 4'd0) addr_bad++;
        noise = noise_en ? (9'($urandom) & ~cls) : 9'd0;
        bus.fu_idone     = (kind == 0 && c == 2 + d) ? (cls | noise) : noise;
        bus.cpu_insn_req = 1'($urandom);
        bus.cpu_rsp_ack  = 1'($urandom);
        cyc();
        c++;
      end
    end
    bus.fu_idone     = 9'd0;
    bus.cpu_insn_req = 1'b0;
    chk("rsp_cycle", 32'(rsp_c), 32'(rsp_at));
    if (!got) begin
      g_resetn = 1'b0; #2; g_resetn = 1'b1;
      return;
    end
    st_seen = bus.cpu_rsp_status;
    chk("status",     32'(bus.cpu_rsp_status), 32'(st));
    chk("ivalid_cyc", 32'(iv_n), 32'(iv_exp));
    chk("init_cyc",   32'(init_n), 32'(init_exp));
    chk("ivalid_val", 32'(iv_bad), 32'd0);
    chk("init_addr",  32'(addr_bad), 32'd0);
    chk("busy_ack",   32'(ack_bad), 32'd0);
    chk("rsp_quiet",  32'({bus.fu_ivalid, bus.crf_init_en, bus.crf_init_addr}), 32'd0);
    bp_bad = 0;
    for (int i = 0; i < bp; i++) begin
      bus.cpu_rsp_ack  = 1'b0;
      bus.cpu_insn_req = 1'($urandom);
      bus.fu_idone     = 9'($urandom);
      cyc();
      if (!bus.cpu_rsp_valid || bus.cpu_rsp_status !== st_seen ||
          bus.cpu_insn_ack || bus.id_encoded !== enc) bp_bad++;
    end
    bus.fu_idone     = 9'd0;
    bus.cpu_insn_req = 1'b0;
    if (bp > 0) chk("backpressure", 32'(bp_bad), 32'd0);
    bus.cpu_rsp_ack = 1'b1;
    cyc();
    bus.cpu_rsp_ack = 1'b0;
    chk("post_ack_rsp",  32'(bus.cpu_rsp_valid), 32'd0);
    chk("post_ack_idle", 32'(bus.cpu_insn_ack), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},    32'(bus.cpu_insn_ack), 32'd1);
    chk({tag, "_rspv"},   32'(bus.cpu_rsp_valid), 32'd0);
    chk({tag, "_status"}, 32'(bus.cpu_rsp_status), 32'd0);
    chk({tag, "_enc"},    bus.id_encoded, 32'd0);
    chk({tag, "_ivalid"}, 32'(bus.fu_ivalid), 32'd0);
    chk({tag, "_crf"},    32'({bus.crf_init_en, bus.crf_init_addr}), 32'd0);
  endtask

  // Start an instruction, assert reset between clock edges after n cycles,
  // and require immediate reset values and no later response.
  task automatic mid_reset(input int kind, input logic [8:0] cls, input int n, input string tag);
    int quiet_bad;
    set_dec(kind, cls);
    accept($urandom | 32'h1);
    repeat (n) cyc();
    if (kind == 0) chk({tag, "_busy"}, 32'(bus.fu_ivalid), 32'(cls));
    else           chk({tag, "_busy"}, 32'(bus.crf_init_en), 32'd1);
    #3;
    g_resetn = 1'b0;
    #1;
    check_reset_vals(tag);
    cyc();
    #3;
    g_resetn = 1'b1;
    quiet_bad = 0;
    repeat (4) begin
      cyc();
      if (bus.cpu_rsp_valid || !bus.cpu_insn_ack) quiet_bad++;
    end
    chk({tag, "_noresp"}, 32'(quiet_bad), 32'd0);
    run_txn(0, 9'h010, 1, 0);
  endtask

  initial begin
    int kind, d, bp, b0, b1;
    logic [8:0] cls;
    bus.cpu_insn_req = 1'b0;
    bus.cpu_insn_enc = 32'd0;
    bus.cpu_rsp_ack  = 1'b0;
    bus.id_exception = 1'b0;
    bus.id_class     = 9'd0;
    bus.id_cprs_init = 1'b0;
    bus.fu_idone     = 9'd0;
    #2;
    check_reset_vals("reset");
    #11;
    g_resetn = 1'b1;
    cyc();

    // Directed corners
    run_txn(0, 9'h004, 4, 0);       // normal issue, done 4 cycles after ivalid
    run_txn(1, 9'h004, 0, 0);       // exception
    run_txn(1, 9'h003, 0, 0);       // exception with multi-bit class
    run_txn(1, 9'h000, 0, 0);       // exception with empty class
    run_txn(0, 9'h003, 0, 0);       // multi-bit class alone
    run_txn(0, 9'h000, 0, 0);       // empty class alone
    run_txn(2, 9'h000, 0, 0);       // init with empty class
    run_txn(0, 9'h001, 100, 0);     // timeout, no done
    noise_en = 1'b1;
    run_txn(0, 9'h001, 100, 0);     // timeout with foreign done bits
    noise_en = 1'b0;
    run_txn(0, 9'h080, TO - 1, 0);  // done on the last timeout cycle
    run_txn(0, 9'h080, TO, 0);      // done one cycle too late
    run_txn(0, 9'h100, 0, 10);      // fastest path plus long backpressure
    mid_reset(0, 9'h020, 4, "rst_wait");
    mid_reset(2, 9'h000, 6, "rst_init");

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, TO + 2);
      bp   = $urandom_range(0, 3);
      b0   = $urandom_range(0, 8);
      b1   = (b0 + $urandom_range(1, 8)) % 9;
      noise_en = 1'($urandom);
      cls = 9'd0;
      cls[b0] = 1'b1;
      if (kind <= 5) begin
        run_txn(0, cls, d, bp);
      end else if (kind == 6) begin
        if (1'($urandom)) cls[b1] = 1'b1;
        else              cls = 9'd0;
        run_txn(0, cls, d, bp);
      end else if (kind == 7) begin
        run_txn(1, 9'($urandom), d, bp);
      end else if (kind == 8) begin
        run_txn(2, 9'($urandom), d, bp);
      end else begin
        run_txn(0, cls, TO + $urandom_range(0, 3), bp);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
